// File: rtl/pc_sequencer_if.sv
// Purpose: bundles the control inputs and status outputs of the program-counter sequencer.
// Latency: none, this is wiring only; the sequencer registers every output.
// Backpressure: none; stall is a per-cycle hold request, not a handshake.
//
// Ports (master = decoder/harness side, slave = sequencer):
//   start, stall, halt, branch_en, target  -> into the sequencer
//   pc, running, done, err, cycle_cnt      <- out of the sequencer
interface pc_sequencer_if #(
    parameter int D  = 8,
    parameter int CW = 16
);
    logic          start;
    logic          stall;
    logic          halt;
    logic          branch_en;
    logic [D-1:0]  target;
    logic [D-1:0]  pc;
    logic          running;
    logic          done;
    logic          err;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output start, stall, halt, branch_en, target,
        input  pc, running, done, err, cycle_cnt
    );

    modport slave (
        input  start, stall, halt, branch_en, target,
        output pc, running, done, err, cycle_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: instruction-fetch PC sequencer (start, increment, absolute branch, stall, halt/done, err).
// Latency: 1 cycle; inputs sampled at edge N take effect on the registered outputs after edge N.
// Backpressure: stall holds pc for one cycle per asserted cycle, with no limit on consecutive stalls.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, overrides all other inputs
//   bus    - pc_sequencer_if.slave: start/stall/halt/branch_en/target in,
//            pc/running/done/err/cycle_cnt out
module pc_sequencer #(
    parameter int D        = 8,
    parameter int PROG_LEN = 64,
    parameter int CW       = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    // One-hot-ish encoding so running/done are plain flop bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // PROG_LEN may equal 2^D, so the range compare is done one bit wider.
    localparam logic [D:0]    PROG_LEN_W = (D+1)'(PROG_LEN);
    localparam logic [D-1:0]  LAST_PC    = D'(PROG_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic          err_q, err_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        err_d       = err_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    pc_d        = '0;
                    err_d       = 1'b0;
                    cycle_cnt_d = '0;
                end
            end

            ST_RUN: begin
                // Every RUN edge counts, including stall, halt and error exits.
                if (cycle_cnt_q != CNT_MAX) begin
                    cycle_cnt_d = cycle_cnt_q + CW'(1);
                end

                if (bus.halt) begin
                    state_d = ST_DONE;
                end else if (bus.stall) begin
                    state_d = ST_RUN;
                end else if (bus.branch_en) begin
                    if ({1'b0, bus.target} < PROG_LEN_W) begin
                        pc_d = bus.target;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end else if (pc_q == LAST_PC) begin
                    // Falling off the end of the program; checked before the
                    // increment so pc never wraps.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            err_q       <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            err_q       <= err_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.running   = state_q[0];
    assign bus.done      = state_q[1];
    assign bus.err       = err_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed, table-driven bench for pc_sequencer (CW=16 main instance, CW=4 saturation instance).
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next rising edge.
// Backpressure: exercised through stall sequences.
module tb_pc_sequencer;

    localparam int D        = 8;
    localparam int PROG_LEN = 64;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.D(D), .CW(16)) if_a ();
    pc_sequencer_if #(.D(D), .CW(4))  if_b ();

    pc_sequencer #(.D(D), .PROG_LEN(PROG_LEN), .CW(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.slave)
    );

    pc_sequencer #(.D(D), .PROG_LEN(PROG_LEN), .CW(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic s, input logic st, input logic h, input logic b, input logic [D-1:0] t);
        if_a.start     = s;
        if_a.stall     = st;
        if_a.halt      = h;
        if_a.branch_en = b;
        if_a.target    = t;
    endtask

    task automatic chk_a(input string tag, input int idx, input logic [D-1:0] pc, input logic run,
                         input logic dn, input logic er, input logic [15:0] cnt);
        chk({tag, ".pc"},      idx, 32'(if_a.pc),        32'(pc));
        chk({tag, ".running"}, idx, 32'(if_a.running),   32'(run));
        chk({tag, ".done"},    idx, 32'(if_a.done),      32'(dn));
        chk({tag, ".err"},     idx, 32'(if_a.err),       32'(er));
        chk({tag, ".cnt"},     idx, 32'(if_a.cycle_cnt), 32'(cnt));
    endtask

    typedef struct {
        logic         start;
        logic         stall;
        logic         halt;
        logic         branch_en;
        logic [D-1:0] target;
        logic [D-1:0] exp_pc;
        logic         exp_running;
        logic         exp_done;
        logic         exp_err;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Table: one row per clock edge, applied after a reset.
        //                start stall halt br  tgt   pc  run dn er cnt
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1, 0, 0, 16'd0});  // start
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd1,  1, 0, 0, 16'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd2,  1, 0, 0, 16'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd3,  1, 0, 0, 16'd3});  // start in RUN ignored
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd22, 8'd22, 1, 0, 0, 16'd4});  // branch at pc=3
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd23, 1, 0, 0, 16'd5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd40, 8'd23, 1, 0, 0, 16'd6});  // stall beats branch
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd40, 8'd23, 1, 0, 0, 16'd7});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 8'd40, 1, 0, 0, 16'd8});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 8'd40, 1, 0, 0, 16'd9});  // branch to self
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd63, 8'd63, 1, 0, 0, 16'd10}); // last legal target
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd64, 8'd63, 0, 1, 1, 16'd11}); // target == PROG_LEN
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'd5,  8'd63, 0, 1, 1, 16'd11}); // DONE holds
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1, 0, 0, 16'd0});  // restart clears err
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd30, 8'd30, 1, 0, 0, 16'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  8'd30, 0, 1, 0, 16'd2});  // halt at pc=30
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  1, 0, 0, 16'd0});  // restart from DONE
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd1,  1, 0, 0, 16'd1});

        drive_a(0, 0, 0, 0, '0);
        if_b.start = 1'b0; if_b.stall = 1'b0; if_b.halt = 1'b0;
        if_b.branch_en = 1'b0; if_b.target = '0;

        // Reset state; start/branch held high to show reset wins.
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(1, 0, 0, 1, 8'd9);
        tick(); tick();
        chk_a("reset", 0, 8'd0, 0, 0, 0, 16'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        drive_a(0, 0, 0, 0, '0);
        tick();
        chk_a("idle", 0, 8'd0, 0, 0, 0, 16'd0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            drive_a(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].branch_en, vecs[i].target);
            tick();
            chk_a("vec", i, vecs[i].exp_pc, vecs[i].exp_running, vecs[i].exp_done,
                  vecs[i].exp_err, vecs[i].exp_cnt);
        end

        // Run off the end of the program from a clean reset.
        rst_a = 1'b1; drive_a(0, 0, 0, 0, '0); tick(); rst_a = 1'b0;
        drive_a(1, 0, 0, 0, '0); tick();
        drive_a(0, 0, 0, 0, '0);
        for (int k = 1; k <= 63; k++) begin
            tick();
            chk("seq.pc", k, 32'(if_a.pc), 32'(k));
        end
        tick();
        chk_a("end", 0, 8'd63, 0, 1, 1, 16'd64);

        // Halt together with stall at pc=7, then out-of-range branch on a new run.
        drive_a(1, 0, 0, 0, '0); tick();
        chk_a("hs_start", 0, 8'd0, 1, 0, 0, 16'd0);
        drive_a(0, 0, 0, 0, '0);
        repeat (7) tick();
        drive_a(0, 1, 1, 0, '0); tick();
        chk_a("halt_stall", 0, 8'd7, 0, 1, 0, 16'd8);
        drive_a(1, 0, 0, 0, '0); tick();
        drive_a(0, 0, 0, 1, 8'd70); tick();
        chk_a("oor", 0, 8'd0, 0, 1, 1, 16'd1);

        // Stall with pending branch at pc=5, then reset mid-run at pc=12.
        drive_a(1, 0, 0, 0, '0); tick();
        chk_a("st_start", 0, 8'd0, 1, 0, 0, 16'd0);
        drive_a(0, 0, 0, 0, '0);
        repeat (5) tick();
        drive_a(0, 1, 0, 1, 8'd40);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.pc",  k, 32'(if_a.pc),        32'd5);
            chk("stall.cnt", k, 32'(if_a.cycle_cnt), 32'(6 + k));
        end
        drive_a(0, 0, 0, 1, 8'd40); tick();
        chk_a("st_br", 0, 8'd40, 1, 0, 0, 16'd9);
        drive_a(0, 0, 0, 1, 8'd12); tick();
        chk_a("to12", 0, 8'd12, 1, 0, 0, 16'd10);
        rst_a = 1'b1; drive_a(1, 0, 0, 1, 8'd20); tick();
        rst_a = 1'b0; drive_a(0, 0, 0, 0, '0);
        chk_a("midrst", 0, 8'd0, 0, 0, 0, 16'd0);

        // Saturation on the CW=4 instance: stall forever after start.
        if_b.start = 1'b1; tick();
        if_b.start = 1'b0; if_b.stall = 1'b1;
        chk("sat.cnt0", 0, 32'(if_b.cycle_cnt), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat.cnt", k, 32'(if_b.cycle_cnt), 32'((k > 15) ? 15 : k));
        end
        chk("sat.pc",      0, 32'(if_b.pc),      32'd0);
        chk("sat.running", 0, 32'(if_b.running), 32'd1);
        if_b.stall = 1'b0; if_b.halt = 1'b1; tick();
        if_b.halt = 1'b0;
        chk("sat.done", 0, 32'(if_b.done),      32'd1);
        chk("sat.hold", 0, 32'(if_b.cycle_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the absolute branch target produced by the branch-target lookup table and advances the instruction-fetch address each cycle. It sits between the control decoder and instruction memory and owns program start, sequential increment, absolute branching, stall hold and halt/done reporting. A small run-cycle counter is exported for the test harness.

## Interface
- D, 8, PC width in bits
- PROG_LEN, 64, number of valid instruction addresses (0 .. PROG_LEN-1); must be ≤ 2^D
- CW, 16, width of run-cycle counter

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- start  in  1  request to begin a program run at PC 0
- stall  in  1  hold PC for this cycle
- halt  in  1  decoder reports a HALT instruction at the current PC
- branch_en  in  1  branch taken this cycle; qualifies target
- target  in  D  absolute branch destination from the lookup table
- pc  out  D  current instruction address, registered
- running  out  1  high while in RUN
- done  out  1  high while in DONE
- err  out  1  sticky: run ended by an out-of-range branch or by falling off the end of the program
- cycle_cnt  out  CW  cycles spent in RUN during the current or last run

## Operation
- States: IDLE, RUN, DONE; encoded so that running = (state==RUN) and done = (state==DONE).
- Reset: state IDLE, pc 0, err 0, cycle_cnt 0, so running 0 and done 0. Reset overrides every other input on the same edge.
- IDLE: start=1 → RUN; pc←0, err←0, cycle_cnt←0. All other inputs ignored.
- RUN, per edge, strict priority:
  1. halt=1 → DONE; pc holds; err unchanged.
  2. stall=1 → stay RUN; pc holds.
  3. branch_en=1: if target < PROG_LEN then pc←target; otherwise DONE, pc holds, err←1.
  4. Otherwise, if pc == PROG_LEN-1 then DONE, pc holds, err←1; else pc←pc+1.
- Halt outranks stall, so a halt on a stalled instruction still terminates the run.
- Branch to the current pc is legal and produces a one-instruction loop.
- start while in RUN is ignored.
- DONE: pc, err and cycle_cnt hold. start=1 → RUN with the same initialisation as from IDLE.
- cycle_cnt: increments on every edge taken while in RUN, including stall, halt and error-exit cycles. It saturates at 2^CW-1 and never wraps.
- Arithmetic: pc+1 computed at D bits. Wrap cannot occur because the end-of-program check precedes the increment.

## Timing
- All outputs are registered. Inputs are sampled at edge N; the effect is visible after edge N.
- start sampled at edge N: running=1 and pc=0 after N; the first instruction executes in cycle N+1.
- Branch latency 1 cycle: branch_en/target sampled at N → pc=target after N. There is no delay slot; the instruction at the old pc+1 is never presented.
- halt sampled at N → done=1 and running=0 after N; pc still shows the HALT address.
- Stall adds exactly one cycle per asserted cycle; there is no cap on consecutive stalls.
- reset asserted mid-run → IDLE after that edge regardless of other inputs; pc returns to 0.

## Test plan
- Reset, then pulse start with no other inputs, PROG_LEN=64 → pc steps 0,1,…,63; after the edge at pc=63, done=1, err=1, pc=63, cycle_cnt=64.
- start; at pc=3 assert branch_en with target=22 → next pc=22, then 23. Later, at pc=30, assert halt → done=1, err=0, pc=30, running=0.
- At pc=5 assert stall for 3 cycles together with branch_en and target=40 → pc stays 5 for 3 cycles. Then drop stall with branch_en still high → pc=40. cycle_cnt counts the stall cycles.
- At pc=7 assert halt and stall in the same cycle → DONE, pc=7. Then branch_en with target=70 (≥ PROG_LEN) on a new run → done=1, err=1, pc unchanged.
- Assert reset while in RUN at pc=12 with branch_en=1 → IDLE, pc=0, running=0, done=0, cycle_cnt=0. start in DONE restarts at pc=0 with err cleared.
- Force cycle_cnt to 2^CW-1 (stall loop with CW=4) → it holds at 15 and does not wrap.
